// File: rtl/csr_pkg.sv
// Shared CSR-side constants for trap handling: cause encodings and the mie
// bit offset of the external interrupt enables.
package csr_pkg;

  localparam logic [31:0] EXC_ILLEGAL_CAUSE = 32'h0000_0002;
  localparam logic [31:0] IRQ_CAUSE_BASE    = 32'h8000_0010;
  localparam int unsigned MIE_IRQ_OFFSET    = 16;
  localparam int unsigned IRQ_IDX_W         = 4;

  function automatic logic [31:0] irq_cause(input logic [IRQ_IDX_W-1:0] idx);
    return IRQ_CAUSE_BASE + {{(32-IRQ_IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Link between the interrupt controller and its priority encoder: masked
// request vector out, lowest-index winner (one-hot and binary) back.
interface irq_controller_if
  import csr_pkg::*;
#(
  parameter int unsigned N = 16
);

  logic [N-1:0]         req;
  logic [N-1:0]         onehot;
  logic [IRQ_IDX_W-1:0] idx;
  logic                 valid;

  modport master (output req, input onehot, input idx, input valid);
  modport slave  (input req, output onehot, output idx, output valid);

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: line 0 wins. Produces one-hot and binary index of
// the lowest set request plus a valid flag.
module irq_prio_enc
  import csr_pkg::*;
#(
  parameter int unsigned N = 16
) (
  irq_controller_if.slave enc
);

  logic [N-1:0]         onehot;
  logic [IRQ_IDX_W-1:0] idx;
  logic                 found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (enc.req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IRQ_IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  assign enc.onehot = onehot;
  assign enc.idx    = idx;
  assign enc.valid  = found;

endmodule

// File: rtl/irq_controller.sv
// Single-level trap controller: illegal-instruction exceptions plus
// level-sensitive interrupts, one handler of each kind at a time.
module irq_controller
  import csr_pkg::*;
#(
  parameter int unsigned IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exception_i,
  input  logic               mret_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  output logic               trap_o,
  output logic               irq_o,
  output logic [31:0]        mcause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o
);

  logic                 exc_h_q, exc_h_d;
  logic                 irq_h_q, irq_h_d;
  logic [IRQ_IDX_W-1:0] irq_idx_q, irq_idx_d;
  logic [IRQ_NUM-1:0]   pending;
  logic                 ack_irq;
  logic                 unused_sink;

  irq_controller_if #(.N(IRQ_NUM)) prio_bus ();

  assign pending      = irq_req_i & mie_i[MIE_IRQ_OFFSET +: IRQ_NUM];
  assign prio_bus.req = pending;

  irq_prio_enc #(.N(IRQ_NUM)) u_prio_enc (
    .enc (prio_bus)
  );

  assign unused_sink = ^{mie_i, prio_bus.onehot};

  // Trap decisions are combinational so the CSR unit captures cause in the
  // same cycle the core redirects.
  always_comb begin
    irq_o  = prio_bus.valid & ~exception_i & ~exc_h_q & ~irq_h_q;
    trap_o = exception_i | irq_o;
    if (exception_i) begin
      mcause_o = EXC_ILLEGAL_CAUSE;
    end else if (irq_o) begin
      mcause_o = irq_cause(prio_bus.idx);
    end else begin
      mcause_o = '0;
    end
  end

  // An MRET closes the exception handler first; reset swallows any ack.
  assign ack_irq = mret_i & ~rst_i & ~exception_i & ~exc_h_q & irq_h_q;

  always_comb begin
    irq_ret_o = '0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      irq_ret_o[i] = ack_irq & (irq_idx_q == IRQ_IDX_W'(i));
    end
  end

  always_comb begin
    exc_h_d   = exc_h_q;
    irq_h_d   = irq_h_q;
    irq_idx_d = irq_idx_q;
    if (exception_i) begin
      exc_h_d = 1'b1;
    end else if (mret_i) begin
      if (exc_h_q) begin
        exc_h_d = 1'b0;
      end else if (irq_h_q) begin
        irq_h_d = 1'b0;
      end
    end
    if (irq_o) begin
      irq_h_d   = 1'b1;
      irq_idx_d = prio_bus.idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exc_h_q   <= 1'b0;
      irq_h_q   <= 1'b0;
      irq_idx_q <= '0;
    end else begin
      exc_h_q   <= exc_h_d;
      irq_h_q   <= irq_h_d;
      irq_idx_q <= irq_idx_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller and its priority encoder: each driven
// cycle queues its expected outputs, popped and compared mid-cycle.
module tb_irq_controller;
  import csr_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_i, exception_i, mret_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        trap_o, irq_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;

  always #5 clk = ~clk;

  irq_controller #(.IRQ_NUM(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .exception_i (exception_i),
    .mret_i      (mret_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .trap_o      (trap_o),
    .irq_o       (irq_o),
    .mcause_o    (mcause_o),
    .irq_ret_o   (irq_ret_o)
  );

  irq_controller_if #(.N(16)) enc_bus ();
  irq_prio_enc #(.N(16)) u_enc (.enc(enc_bus));

  typedef struct {
    logic r, e, m;
    logic [15:0] rq;
    logic [31:0] mi;
    logic t, i;
    logic [31:0] c;
    logic [15:0] rt;
  } row_t;

  typedef struct {
    logic t, i;
    logic [31:0] c;
    logic [15:0] rt;
  } exp_t;

  typedef struct {
    logic [15:0] oh;
    logic [3:0]  ix;
    logic        v;
  } enc_exp_t;

  exp_t     sb[$];
  enc_exp_t enc_sb[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic row_t rw(input logic r, input logic e, input logic m,
                              input logic [15:0] rq, input logic [31:0] mi,
                              input logic t, input logic i,
                              input logic [31:0] c, input logic [15:0] rt);
    row_t x;
    x.r = r; x.e = e; x.m = m; x.rq = rq; x.mi = mi;
    x.t = t; x.i = i; x.c = c; x.rt = rt;
    return x;
  endfunction

  task automatic drive(input row_t x);
    exp_t ex;
    rst_i = x.r; exception_i = x.e; mret_i = x.m; irq_req_i = x.rq; mie_i = x.mi;
    ex.t = x.t; ex.i = x.i; ex.c = x.c; ex.rt = x.rt;
    sb.push_back(ex);
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0, L, L, 32'h0, 16'h0));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0, L, L, 32'h0, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0000, 32'h0, L, L, 32'h0, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0, L, L, 32'h0, 16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL reset[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, H, H, 32'h8000_0010, 16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0001));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h8000, 32'hFFFF_0000, H, H, 32'h8000_001F, 16'h0));
    rows.push_back(rw(L, L, H, 16'h8000, 32'hFFFF_0000, L, L, 32'h0,          16'h8000));
    rows.push_back(rw(L, L, L, 16'h0000, 32'hFFFF_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL basic[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0006, 32'h0006_0000, H, H, 32'h8000_0011, 16'h0));
    rows.push_back(rw(L, L, L, 16'h0006, 32'h0006_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0006, 32'h0006_0000, L, L, 32'h0,          16'h0002));
    rows.push_back(rw(L, L, L, 16'h0004, 32'h0006_0000, H, H, 32'h8000_0012, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0004, 32'h0006_0000, L, L, 32'h0,          16'h0004));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0006_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL priority[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_mask();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0, L, L, 32'h0, 16'h0));
    for (int n = 0; n < 10; n++) rows.push_back(rw(L, L, L, 16'h0008, 32'h0, L, L, 32'h0, 16'h0));
    rows.push_back(rw(L, L, L, 16'h0008, 32'h0008_0000, H, H, 32'h8000_0013, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0008, 32'h0,         L, L, 32'h0,          16'h0008));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL mask[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_exception();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, H, L, 16'h0001, 32'h0001_0000, H, L, 32'h2,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, H, H, 32'h8000_0010, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0001));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0001_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL exception[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_exc_mret();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, H, L, 16'h0000, 32'h0001_0000, H, L, 32'h2,          16'h0));
    rows.push_back(rw(L, H, H, 16'h0001, 32'h0001_0000, H, L, 32'h2,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0001, 32'h0001_0000, H, H, 32'h8000_0010, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0001, 32'h0001_0000, L, L, 32'h0,          16'h0001));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0001_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL exc_mret[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_nested();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0020, 32'h0020_0000, H, H, 32'h8000_0015, 16'h0));
    rows.push_back(rw(L, H, L, 16'h0020, 32'h0020_0000, H, L, 32'h2,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0020, 32'h0020_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0020, 32'h0020_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0020, 32'h0020_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, H, 16'h0020, 32'h0020_0000, L, L, 32'h0,          16'h0020));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0020_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL nested[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_handler();
    row_t rows[$];
    exp_t e;
    rows.push_back(rw(H, L, L, 16'h0000, 32'h0,         L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0004, 32'h0004_0000, H, H, 32'h8000_0012, 16'h0));
    rows.push_back(rw(L, L, L, 16'h0004, 32'h0004_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(H, L, H, 16'h0004, 32'h0004_0000, L, L, 32'h0,          16'h0));
    rows.push_back(rw(L, L, L, 16'h0004, 32'h0004_0000, H, H, 32'h8000_0012, 16'h0));
    rows.push_back(rw(L, L, H, 16'h0004, 32'h0004_0000, L, L, 32'h0,          16'h0004));
    rows.push_back(rw(L, L, L, 16'h0000, 32'h0004_0000, L, L, 32'h0,          16'h0));
    foreach (rows[k]) begin
      drive(rows[k]);
      e = sb.pop_front();
      vectors++;
      if (trap_o !== e.t || irq_o !== e.i || mcause_o !== e.c || irq_ret_o !== e.rt) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got trap=%b irq=%b mcause=%h ret=%h, expected trap=%b irq=%b mcause=%h ret=%h",
                 k, trap_o, irq_o, mcause_o, irq_ret_o, e.t, e.i, e.c, e.rt);
      end
      tick();
    end
  endtask

  task automatic test_prio_enc();
    logic [15:0] pat[$];
    logic [15:0] r;
    enc_exp_t    x, e;
    pat.push_back(16'h0000);
    pat.push_back(16'h8000);
    pat.push_back(16'hFFFF);
    pat.push_back(16'h0001);
    pat.push_back(16'h0300);
    for (int n = 0; n < 8; n++) pat.push_back(16'($urandom));
    foreach (pat[k]) begin
      r = pat[k];
      enc_bus.req = r;
      x.oh = r & (~r + 16'd1);
      x.v  = |r;
      x.ix = '0;
      for (int b = 15; b >= 0; b--) if (r[b]) x.ix = 4'(b);
      enc_sb.push_back(x);
      #1;
      e = enc_sb.pop_front();
      vectors++;
      if (enc_bus.onehot !== e.oh || enc_bus.idx !== e.ix || enc_bus.valid !== e.v) begin
        miscompares++;
        $display("FAIL prio_enc[%0d] req=%h: got onehot=%h idx=%0d valid=%b, expected onehot=%h idx=%0d valid=%b",
                 k, r, enc_bus.onehot, enc_bus.idx, enc_bus.valid, e.oh, e.ix, e.v);
      end
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    exception_i = 1'b0;
    mret_i      = 1'b0;
    irq_req_i   = '0;
    mie_i       = '0;
    enc_bus.req = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_exception();
    test_exc_mret();
    test_nested();
    test_reset_mid_handler();
    test_prio_enc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
